// File: rtl/fpu_addsub_arbiter.sv
// -----------------------------------------------------------------------------
// fpu_addsub_arbiter
//
// Purpose: lets two floating-point issue sources share one in-order add/sub
// unit. At most one operation is issued per cycle. The requester ID of each
// issued operation is pushed into an in-order tag FIFO. Each result returned by
// the unit pops the FIFO head, and that ID steers the response strobe.
//
// Configuration macro: FPU_ARB_RR_EN
//   defined   -> round-robin tie-break (the requester that is not last_grant wins)
//   undefined -> fixed priority (requester 0 always wins a tie)
//
// Ports:
//   i_clk, i_rst                    clock (rising edge), async active-high reset
//   i_reqX_valid / o_reqX_ready     request handshake, X = 0, 1
//   i_reqX_add_sub, i_reqX_a/_b     operation (0 = add, 1 = sub) and operands
//   o_fpu_valid, o_fpu_add_sub,
//   o_fpu_a, o_fpu_b                registered issue to the FP unit
//   i_fpu_valid, i_fpu_result       in-order result return from the FP unit
//   o_rsp0_valid, o_rsp1_valid      one-cycle response strobes, no backpressure
//   o_rsp_result                    response data shared by both strobes
//   o_busy                          tag FIFO non-empty
//   o_err                           sticky: a result arrived with no tag outstanding
//
// Handshake: an operation transfers in any cycle where valid && ready are both
// high. Ready depends only on the valids and registered state. It is never
// high without its valid, and it is never high on both ports at once. A pop in
// the same cycle does not free a slot for the current cycle.
// -----------------------------------------------------------------------------
module fpu_addsub_arbiter #(
    parameter int DEPTH = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req0_valid,
    output logic        o_req0_ready,
    input  logic        i_req0_add_sub,
    input  logic [31:0] i_req0_a,
    input  logic [31:0] i_req0_b,
    input  logic        i_req1_valid,
    output logic        o_req1_ready,
    input  logic        i_req1_add_sub,
    input  logic [31:0] i_req1_a,
    input  logic [31:0] i_req1_b,
    output logic        o_fpu_valid,
    output logic        o_fpu_add_sub,
    output logic [31:0] o_fpu_a,
    output logic [31:0] o_fpu_b,
    input  logic        i_fpu_valid,
    input  logic [31:0] i_fpu_result,
    output logic        o_rsp0_valid,
    output logic        o_rsp1_valid,
    output logic [31:0] o_rsp_result,
    output logic        o_busy,
    output logic        o_err
);

    // A depth of 1 still needs a one-bit pointer. That pointer simply stays at 0.
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [DEPTH-1:0] tag_q, tag_d;
    logic             last_grant_q, last_grant_d;
    logic             err_q, err_d;
    logic             fpu_valid_q, fpu_valid_d;
    logic             fpu_add_sub_q, fpu_add_sub_d;
    logic [31:0]      fpu_a_q, fpu_a_d;
    logic [31:0]      fpu_b_q, fpu_b_d;
    logic             rsp0_valid_q, rsp0_valid_d;
    logic             rsp1_valid_q, rsp1_valid_d;
    logic [31:0]      rsp_result_q, rsp_result_d;

    logic can_issue, tie_pick0, grant0, grant1, push, pop, pop_id;

    always_comb begin
        can_issue = (count_q != CNT_FULL);
`ifdef FPU_ARB_RR_EN
        tie_pick0 = last_grant_q;
`else
        // Fixed priority: requester 0 always wins. last_grant_q still appears
        // in the term, so the register is kept the same in both builds.
        tie_pick0 = 1'b1 | last_grant_q;
`endif
        grant0 = can_issue & i_req0_valid & (~i_req1_valid | tie_pick0);
        grant1 = can_issue & i_req1_valid & (~i_req0_valid | ~tie_pick0);
        push   = grant0 | grant1;
        pop    = i_fpu_valid & (count_q != '0);
        pop_id = tag_q[rd_ptr_q];
    end

    assign o_req0_ready = grant0;
    assign o_req1_ready = grant1;

    always_comb begin
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        tag_d         = tag_q;
        last_grant_d  = last_grant_q;
        err_d         = err_q;
        fpu_valid_d   = push;
        fpu_add_sub_d = fpu_add_sub_q;
        fpu_a_d       = fpu_a_q;
        fpu_b_d       = fpu_b_q;
        rsp0_valid_d  = pop & ~pop_id;
        rsp1_valid_d  = pop & pop_id;
        rsp_result_d  = rsp_result_q;

        if (push) begin
            fpu_add_sub_d   = grant1 ? i_req1_add_sub : i_req0_add_sub;
            fpu_a_d         = grant1 ? i_req1_a : i_req0_a;
            fpu_b_d         = grant1 ? i_req1_b : i_req0_b;
            tag_d[wr_ptr_q] = grant1;
            last_grant_d    = grant1;
            wr_ptr_d        = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
        end

        if (pop) begin
            rsp_result_d = i_fpu_result;
            rd_ptr_d     = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
        end

        // A result with nothing outstanding leaves the FIFO unchanged and is only flagged.
        if (i_fpu_valid && count_q == '0) begin
            err_d = 1'b1;
        end

        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            tag_q         <= '0;
            last_grant_q  <= 1'b1;
            err_q         <= 1'b0;
            fpu_valid_q   <= 1'b0;
            fpu_add_sub_q <= 1'b0;
            fpu_a_q       <= '0;
            fpu_b_q       <= '0;
            rsp0_valid_q  <= 1'b0;
            rsp1_valid_q  <= 1'b0;
            rsp_result_q  <= '0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            tag_q         <= tag_d;
            last_grant_q  <= last_grant_d;
            err_q         <= err_d;
            fpu_valid_q   <= fpu_valid_d;
            fpu_add_sub_q <= fpu_add_sub_d;
            fpu_a_q       <= fpu_a_d;
            fpu_b_q       <= fpu_b_d;
            rsp0_valid_q  <= rsp0_valid_d;
            rsp1_valid_q  <= rsp1_valid_d;
            rsp_result_q  <= rsp_result_d;
        end
    end

    assign o_fpu_valid   = fpu_valid_q;
    assign o_fpu_add_sub = fpu_add_sub_q;
    assign o_fpu_a       = fpu_a_q;
    assign o_fpu_b       = fpu_b_q;
    assign o_rsp0_valid  = rsp0_valid_q;
    assign o_rsp1_valid  = rsp1_valid_q;
    assign o_rsp_result  = rsp_result_q;
    assign o_busy        = (count_q != '0);
    assign o_err         = err_q;

endmodule
